fifo_lookahead_adapter: RTL and testbench

Read-side converter that sits on the read port of a non-lookahead FIFO, where dout is valid the cycle after rd. It presents a lookahead interface downstream: dout shows the head word whenever empty is low, and rd pops it.
It serves consumers that need a lookahead FIFO but sit on a plain FIFO instance.
It sustains one word per cycle and holds up to two prefetched words internally.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_lookahead_adapter_buf.sv | 41 ++++
 rtl/fifo_lookahead_adapter.sv | 68 ++++++
 tb/tb_fifo_lookahead_adapter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the lookahead read adapter.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  // Occupancy of the 2-entry prefetch buffer: 0, 1 or 2 words.
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_MAX = 2'd2;
endpackage

// File: rtl/fifo_lookahead_adapter_buf.sv
// Two-entry prefetch register file with wrapping write/read pointers.
module fifo_lookahead_adapter_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_adv_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;

  always_comb begin
    wptr_d = wptr_q ^ wr_en_i;
    rptr_d = rptr_q ^ rd_adv_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Data storage carries no reset; the occupancy count masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];

endmodule

// File: rtl/fifo_lookahead_adapter.sv
// Converts a FIFO whose dout lags rd by one cycle into a lookahead (show-ahead) read port.
module fifo_lookahead_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  u_empty,
  output logic                  u_rd,
  input  logic [DATA_WIDTH-1:0] u_dout,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH_LOG2 != 1) begin : g_bad_depth
      $error("fifo_lookahead_adapter supports only DEPTH_LOG2 = 1");
    end
  endgenerate

  occ_t                  cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [2:0]            occ;
  logic                  pop;
  logic                  cap;
  logic [DATA_WIDTH-1:0] head;

  // Words held plus the word already requested; never allowed past OCC_MAX.
  assign occ   = {1'b0, cnt_q} + {2'b00, pend_q};
  assign empty = (cnt_q == 2'd0);
  assign pop   = rd & ~empty;
  assign cap   = pend_q & ~rst;

  assign u_rd = ~rst & ~u_empty &
                ((occ < {1'b0, OCC_MAX}) | ((occ == {1'b0, OCC_MAX}) & pop));

  always_comb begin
    pend_d = u_rd;
    cnt_d  = occ_t'(occ - {2'b00, pop});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  fifo_lookahead_adapter_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (cap),
    .wr_data_i(u_dout),
    .rd_adv_i (pop & ~rst),
    .rd_data_o(head)
  );

  assign dout = empty ? '0 : head;

endmodule

// File: tb/tb_fifo_lookahead_adapter.sv
// Scoreboard bench: upstream non-lookahead FIFO model, directed stimulus, negedge monitor.
module tb_fifo_lookahead_adapter;

  localparam int K_EMPTY   = 0;
  localparam int K_DOUT    = 1;
  localparam int K_IDLE    = 2;
  localparam int K_URDCLR  = 3;
  localparam int K_URDCNT  = 4;
  localparam int K_DRAINED = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       u_empty;
  logic       u_rd;
  logic [7:0] u_dout;
  logic       empty;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       stall = 1'b0;

  // Upstream FIFO contents; up_wr written by stimulus, up_rd by the upstream model.
  int up_mem [0:1023];
  int up_wr = 0;
  int up_rd = 0;

  // Scoreboard of expected words; exp_wr by stimulus, exp_rd by monitor.
  int exp_mem [0:1023];
  int exp_wr = 0;
  int exp_rd = 0;

  // Point-in-time checks requested by stimulus, executed by the monitor.
  int req_kind [0:511];
  int req_val  [0:511];
  int req_wr = 0;
  int req_rd = 0;

  int n_cmp   = 0;
  int n_fail  = 0;
  int urd_cnt = 0;

  always #5 clk = ~clk;

  assign u_empty = stall | (up_rd == up_wr);

  fifo_lookahead_adapter #(
    .DATA_WIDTH(8),
    .DEPTH_LOG2(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .u_empty(u_empty),
    .u_rd   (u_rd),
    .u_dout (u_dout),
    .empty  (empty),
    .rd     (rd),
    .dout   (dout)
  );

  always @(posedge clk) begin
    if (rst) begin
      up_rd <= up_wr;
    end else if (u_rd) begin
      u_dout <= up_mem[up_rd][7:0];
      up_rd  <= up_rd + 1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    while (req_rd < req_wr) begin
      case (req_kind[req_rd])
        K_EMPTY:   check("empty", int'(empty), req_val[req_rd]);
        K_DOUT:    check("dout_head", int'(dout), req_val[req_rd]);
        K_IDLE: begin
          check("idle_empty", int'(empty), 1);
          check("idle_dout", int'(dout), 0);
          check("idle_u_rd", int'(u_rd), 0);
        end
        K_URDCLR:  urd_cnt = 0;
        K_URDCNT:  check("u_rd_pulses", urd_cnt, req_val[req_rd]);
        K_DRAINED: check("words_left", exp_wr - exp_rd, 0);
        default:   ;
      endcase
      req_rd++;
    end
    if (rst) begin
      check("u_rd_in_reset", int'(u_rd), 0);
      exp_rd = exp_wr;
    end
    if (u_rd) urd_cnt++;
    check("occupancy_le2", int'(int'(dut.cnt_q) + int'(dut.pend_q) <= 2), 1);
    if (!rst && !empty && rd) begin
      if (exp_rd == exp_wr) begin
        check("extra_pop", int'(dout), -1);
      end else begin
        check("popped_word", int'(dout), exp_mem[exp_rd]);
        exp_rd++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int kind, input int val);
    req_kind[req_wr] = kind;
    req_val[req_wr]  = val;
    req_wr++;
  endtask

  task automatic push(input int w);
    up_mem[up_wr]   = w;
    exp_mem[exp_wr] = w;
    up_wr++;
    exp_wr++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    // Reset then idle, with rd toggling while empty
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req(K_IDLE, 0);
      rd = i[0];
      step();
    end
    rd = 1'b0;
    step();

    // Single word with latency and hold
    req(K_URDCLR, 0);
    push('hA5);
    step();
    req(K_EMPTY, 1);
    step();
    req(K_EMPTY, 0);
    req(K_DOUT, 'hA5);
    for (int i = 0; i < 10; i++) begin
      step();
      req(K_EMPTY, 0);
      req(K_DOUT, 'hA5);
    end
    req(K_URDCNT, 1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    req(K_EMPTY, 1);
    step();

    // Streaming 0x00..0x3F with rd held high
    rd = 1'b1;
    for (int i = 0; i < 64; i++) push(i);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (!empty) found = 1'b1;
      else step();
    end
    if (!found) req(K_EMPTY, 0);
    repeat (64) step();
    req(K_DRAINED, 0);
    req(K_EMPTY, 1);
    rd = 1'b0;
    step();

    // Backpressure: only two words prefetched while rd is low
    req(K_URDCLR, 0);
    for (int i = 0; i < 16; i++) push('h80 + i);
    repeat (20) step();
    req(K_URDCNT, 2);
    req(K_EMPTY, 0);
    req(K_DOUT, 'h80);
    rd = 1'b1;
    repeat (20) step();
    rd = 1'b0;
    req(K_DRAINED, 0);
    req(K_EMPTY, 1);
    step();

    // Random rd and upstream stalls
    for (int i = 0; i < 40; i++) push('hC0 + i);
    for (int i = 0; i < 300; i++) begin
      rd    = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      step();
    end
    stall = 1'b0;
    rd    = 1'b1;
    repeat (50) step();
    rd = 1'b0;
    req(K_DRAINED, 0);
    req(K_EMPTY, 1);
    step();

    // Reset while full with a word in flight, then refill
    for (int i = 0; i < 4; i++) push('h10 + i);
    repeat (6) step();
    req(K_EMPTY, 0);
    req(K_DOUT, 'h10);
    rd = 1'b1;
    step();
    rd  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req(K_EMPTY, 1);
    req(K_DOUT, 0);
    req(K_URDCLR, 0);
    repeat (3) begin
      step();
      req(K_EMPTY, 1);
    end
    req(K_URDCNT, 0);
    push('h77);
    step();
    step();
    req(K_EMPTY, 0);
    req(K_DOUT, 'h77);
    rd = 1'b1;
    step();
    rd = 1'b0;
    req(K_EMPTY, 1);
    req(K_DRAINED, 0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
